// File: rtl/vred_seq.sv
// vred_seq: reduction issue sequencer. Takes one reduction request, streams
// the source register group from the VRF into the reduction unit as framed
// beats, then waits for the unit's result strobe and pulses done.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   req_*              request handshake and fields (accepted only in IDLE)
//   rd_en/rd_addr      VRF read port request; rd_data returns 1 cycle later
//   red_*              reduction unit input beat and latched request fields
//   red_out_valid      result strobe from the reduction unit
//   busy, done         status; done is a one-cycle completion pulse
//
// Build option: define VRED_TAIL_FILL_EN to replace the inactive tail lanes
// of the last beat with the identity of the selected op. Without it the
// source data is passed through and vl must be a whole number of lines.

module vred_seq #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int VL_WIDTH    = 11,
  parameter int OPSEL_WIDTH = 3,
  parameter int SEW_WIDTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [VL_WIDTH-1:0]    req_vl,
  input  logic [SEW_WIDTH-1:0]   req_sew,
  input  logic [OPSEL_WIDTH-1:0] req_opSel,
  input  logic                   req_lop_sum,
  input  logic [ADDR_WIDTH-1:0]  req_src_addr,
  input  logic [DATA_WIDTH-1:0]  req_vs1,
  input  logic [ADDR_WIDTH-1:0]  req_dst_addr,
  output logic                   rd_en,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  input  logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   red_valid,
  output logic                   red_start,
  output logic                   red_end,
  output logic                   red_lop_sum,
  output logic [DATA_WIDTH-1:0]  red_vec0,
  output logic [DATA_WIDTH-1:0]  red_vec1,
  output logic [OPSEL_WIDTH-1:0] red_opSel,
  output logic [SEW_WIDTH-1:0]   red_sew,
  output logic [ADDR_WIDTH-1:0]  red_addr,
  input  logic                   red_out_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int EPL_SH = $clog2(NB);
  localparam int LW     = VL_WIDTH + 1;
  localparam logic [LW-1:0] EPL_MAX = LW'(NB);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [VL_WIDTH-1:0]    r_cnt;
  logic [VL_WIDTH-1:0]    r_last;
  logic [SEW_WIDTH-1:0]   r_sew;
  logic [OPSEL_WIDTH-1:0] r_op;
  logic                   r_lop;
  logic [ADDR_WIDTH-1:0]  r_src;
  logic [DATA_WIDTH-1:0]  r_vs1;
  logic [ADDR_WIDTH-1:0]  r_dst;
  logic                   r_done;
  logic                   r_bv;
  logic [VL_WIDTH-1:0]    r_bidx;

  logic                   w_accept;
  logic                   w_zero_req;
  logic                   w_done_nxt;
  logic                   w_last_rd;
  logic [LW-1:0]          w_epl;
  logic [LW-1:0]          w_mask;
  logic [LW-1:0]          w_lines;
  logic [3:0]             w_sh;
  logic                   w_last_beat;

  // Line count: ceil(vl / epl), epl a power of two.
  always_comb begin
    w_epl   = EPL_MAX >> req_sew;
    w_mask  = w_epl - 1'b1;
    w_sh    = 4'(EPL_SH) - 4'(req_sew);
    w_lines = ({1'b0, req_vl} + w_mask) >> w_sh;
  end

  assign w_accept   = (r_state == S_IDLE) & req_valid
                    & (req_vl != '0);
  assign w_zero_req = (r_state == S_IDLE) & req_valid
                    & (req_vl == '0);
  assign w_last_rd  = (r_cnt == r_last);
  assign w_done_nxt = w_zero_req
                    | ((r_state == S_WAIT) & red_out_valid);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_READ;
      S_READ:  if (w_last_rd) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_WAIT;
      S_WAIT:  if (red_out_valid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b1;
    rd_en     = 1'b0;
    rd_addr   = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_READ: begin
        rd_en   = 1'b1;
        rd_addr = r_src + ADDR_WIDTH'(r_cnt);
      end
      default: ;
    endcase
  end

  // Request latch, line counter and the beat pipeline that tracks the
  // one-cycle VRF read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_last <= '0;
      r_sew  <= '0;
      r_op   <= '0;
      r_lop  <= 1'b0;
      r_src  <= '0;
      r_vs1  <= '0;
      r_dst  <= '0;
      r_done <= 1'b0;
      r_bv   <= 1'b0;
      r_bidx <= '0;
    end else begin
      r_done <= w_done_nxt;
      r_bv   <= (r_state == S_READ);
      r_bidx <= r_cnt;
      if (w_accept) begin
        r_cnt  <= '0;
        r_last <= VL_WIDTH'(w_lines - 1'b1);
        r_sew  <= req_sew;
        r_op   <= req_opSel;
        r_lop  <= req_lop_sum;
        r_src  <= req_src_addr;
        r_vs1  <= req_vs1;
        r_dst  <= req_dst_addr;
      end else if (r_state == S_READ) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign w_last_beat = r_bv & (r_bidx == r_last);

  assign red_valid   = r_bv;
  assign red_start   = r_bv & (r_bidx == '0);
  assign red_end     = w_last_beat;
  assign red_lop_sum = r_lop;
  assign red_vec1    = r_vs1;
  assign red_opSel   = r_op;
  assign red_sew     = r_sew;
  assign red_addr    = r_dst;
  assign done        = r_done;

`ifdef VRED_TAIL_FILL_EN
  logic [VL_WIDTH-1:0] r_tail;
  logic [VL_WIDTH-1:0] w_tail;

  assign w_tail = req_vl & w_mask[VL_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tail <= '0;
    end else if (w_accept) begin
      r_tail <= w_tail;
    end
  end

  // Per-byte fill: a byte is replaced when its lane is at or past the
  // tail count on the last beat. The top byte of each element carries
  // the sign-dependent part of the min/max identities.
  always_comb begin
    int  w_lane;
    int  w_esz;
    logic w_top;
    logic [7:0] w_id;
    red_vec0 = '0;
    if (r_bv) begin
      red_vec0 = rd_data;
      w_esz = 1 << r_sew;
      for (int b = 0; b < NB; b++) begin
        w_lane = b >> r_sew;
        w_top  = ((b % w_esz) == (w_esz - 1));
        w_id   = 8'h00;
        if (r_lop) begin
          if (r_op[1:0] == 2'b01) w_id = 8'hFF;
        end else begin
          unique case (1'b1)
            (r_op[2:1] == 2'b01): w_id = w_top ? 8'h7F : 8'hFF;
            (r_op[2:1] == 2'b10): w_id = w_top ? 8'h80 : 8'h00;
            (r_op[2:1] == 2'b11): w_id = 8'hFF;
            default:              w_id = 8'h00;
          endcase
        end
        if (w_last_beat && (r_tail != '0)
            && (w_lane >= int'(r_tail))) begin
          red_vec0[b*8 +: 8] = w_id;
        end
      end
    end
  end
`else
  assign red_vec0 = r_bv ? rd_data : '0;
`endif

endmodule

// File: tb/tb_vred_seq.sv
// tb_vred_seq: scoreboard bench for vred_seq.
// Expected reads and beats are queued at issue, checked as the DUT emits them.

module tb_vred_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [10:0] req_vl = '0;
  logic [1:0]  req_sew = '0;
  logic [2:0]  req_opSel = '0;
  logic        req_lop_sum = 1'b0;
  logic [31:0] req_src_addr = '0;
  logic [63:0] req_vs1 = '0;
  logic [31:0] req_dst_addr = '0;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [63:0] rd_data = '0;
  logic        red_valid, red_start, red_end, red_lop_sum;
  logic [63:0] red_vec0, red_vec1;
  logic [2:0]  red_opSel;
  logic [1:0]  red_sew;
  logic [31:0] red_addr;
  logic        red_out_valid;
  logic        busy, done;

  logic ru_pulse = 1'b0;
  logic tb_rov = 1'b0;
  int   ru_cnt = 0;
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;

  assign red_out_valid = ru_pulse | tb_rov;

  vred_seq dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vl(req_vl), .req_sew(req_sew),
    .req_opSel(req_opSel), .req_lop_sum(req_lop_sum),
    .req_src_addr(req_src_addr), .req_vs1(req_vs1),
    .req_dst_addr(req_dst_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .red_valid(red_valid), .red_start(red_start),
    .red_end(red_end), .red_lop_sum(red_lop_sum),
    .red_vec0(red_vec0), .red_vec1(red_vec1),
    .red_opSel(red_opSel), .red_sew(red_sew),
    .red_addr(red_addr), .red_out_valid(red_out_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
  } rd_t;

  typedef struct {
    int          cyc;
    logic [63:0] v0;
    logic [63:0] v1;
    logic        st;
    logic        en;
    logic        lop;
    logic [2:0]  op;
    logic [1:0]  sew;
    logic [31:0] dst;
  } beat_t;

  rd_t   rq[$];
  beat_t bq[$];

  function automatic logic [63:0] line_data(input logic [31:0] a);
    return {a ^ 32'hC3A5_0F1E, a * 32'h9E37_79B1 + 32'h1234_5678};
  endfunction

  always @(posedge clk) if (rd_en) rd_data <= line_data(rd_addr);

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0d", tag, got, exp, cyc);
    end
  endtask

  // Lane-level model of the tail fill.
  function automatic logic [63:0] fill_model(input logic [63:0] d,
      input int sew, input int tail, input logic lop, input logic [2:0] op);
    int esz;
    int epl;
    logic [63:0] ones, id, r;
    esz  = 8 << sew;
    epl  = 8 >> sew;
    ones = (esz == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << esz) - 1);
    r    = d;
    if (lop) id = (op[1:0] == 2'b01) ? ones : 64'd0;
    else begin
      case (op[2:1])
        2'b00:   id = 64'd0;
        2'b01:   id = ones >> 1;
        2'b10:   id = ones ^ (ones >> 1);
        default: id = ones;
      endcase
    end
    if (tail != 0)
      for (int l = tail; l < epl; l++)
        r = (r & ~(ones << (l * esz))) | (id << (l * esz));
`ifdef VRED_TAIL_FILL_EN
    return r;
`else
    return d;
`endif
  endfunction

  // Monitor + 6-cycle reduction unit model.
  always @(negedge clk) begin
    if (!rst) begin
      ru_cnt   = 0;
      ru_pulse = 1'b0;
    end else begin
      if (ru_cnt > 0) begin
        ru_cnt--;
        ru_pulse = (ru_cnt == 0);
      end else ru_pulse = 1'b0;
      if (rd_en) begin
        if (rq.size() == 0) check("rd_en_spurious", 1, 0);
        else begin
          rd_t e;
          e = rq.pop_front();
          check("rd_addr", rd_addr, e.addr);
          check("rd_cyc", cyc, e.cyc);
        end
      end
      if (red_valid) begin
        if (bq.size() == 0) check("beat_spurious", 1, 0);
        else begin
          beat_t b;
          b = bq.pop_front();
          check("beat_cyc", cyc, b.cyc);
          check("vec0", red_vec0, b.v0);
          check("vec1", red_vec1, b.v1);
          check("start_end", {red_start, red_end}, {b.st, b.en});
          check("fields", {red_lop_sum, red_opSel, red_sew, red_addr},
                {b.lop, b.op, b.sew, b.dst});
        end
        if (red_end) ru_cnt = 6;
      end
    end
  end

  task automatic issue(input int vl, input int sew, input logic [2:0] op,
      input logic lop, input logic [31:0] src, input logic [63:0] vs1,
      input logic [31:0] dst, output int t);
    int k;
    int epl;
    int n;
    int tail;
    logic [31:0] a;
    k    = 0;
    epl  = 8 >> sew;
    n    = (vl + epl - 1) / epl;
    tail = vl % epl;
    while (!req_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) check("ready_timeout", 0, 1);
    req_vl       = 11'(vl);
    req_sew      = 2'(sew);
    req_opSel    = op;
    req_lop_sum  = lop;
    req_src_addr = src;
    req_vs1      = vs1;
    req_dst_addr = dst;
    req_valid    = 1'b1;
    t = cyc;
    for (int i = 0; i < n; i++) begin
      a = src + 32'(i);
      rq.push_back('{t + 1 + i, a});
      bq.push_back('{t + 2 + i,
        fill_model(line_data(a), sew, (i == n - 1) ? tail : 0, lop, op),
        vs1, i == 0, i == n - 1, lop, op, 2'(sew), dst});
    end
  endtask

  task automatic finish_req(input int t, input int vl, input int sew,
                            input bit hold);
    int epl;
    int n;
    int exp_done;
    int k;
    epl = 8 >> sew;
    n   = (vl + epl - 1) / epl;
    exp_done = (vl == 0) ? t + 1 : t + n + 8;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    check("busy_ready", {busy, req_ready}, (vl == 0) ? 2'b01 : 2'b10);
    k = 0;
    while (!done && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (!done) check("done_timeout", 0, 1);
    else check("done_cycle", cyc, exp_done);
    check("ready_at_done", req_ready, 1);
  endtask

  initial begin
    int t;
    int t2;
    int sw;
    int seen;
    repeat (3) @(negedge clk);
    check("rst_flags",
      {rd_en, red_valid, red_start, red_end, red_lop_sum, done, busy,
       req_ready}, 8'b0000_0001);
    check("rst_addr", {rd_addr, red_addr}, 64'd0);
    check("rst_vec", red_vec0 | red_vec1, 64'd0);
    check("rst_op_sew", {red_opSel, red_sew}, 5'd0);
    rst = 1'b1;
    @(negedge clk);

    issue(8, 0, 3'b000, 1'b0, 32'h40, 64'h1111_2222_3333_4444,
          32'hD00, t);
    finish_req(t, 8, 0, 0);
    @(negedge clk);
    check("done_pulse_low", done, 0);

    issue(5, 2, 3'b000, 1'b0, 32'h10, 64'hA, 32'hD10, t);
    finish_req(t, 5, 2, 0);

    issue(6, 1, 3'b001, 1'b1, 32'h20, 64'hB, 32'hD20, t);
    finish_req(t, 6, 1, 0);

    issue(3, 0, 3'b010, 1'b0, 32'h30, 64'hC, 32'hD30, t);
    finish_req(t, 3, 0, 0);

    issue(4, 3, 3'b100, 1'b0, 32'hFFFF_FFFE, 64'hD, 32'hD40, t);
    finish_req(t, 4, 3, 0);

    issue(0, 0, 3'b000, 1'b0, 32'h50, 64'hE, 32'hD50, t);
    finish_req(t, 0, 0, 0);
    @(negedge clk);
    check("vl0_quiet", {busy, done}, 2'b00);

    issue(4, 2, 3'b011, 1'b1, 32'h60, 64'hF, 32'hD60, t);
    finish_req(t, 4, 2, 1);
    issue(4, 2, 3'b011, 1'b1, 32'h60, 64'hF, 32'hD60, t2);
    finish_req(t2, 4, 2, 0);

    for (int r = 0; r < 6; r++) begin
      sw = int'($urandom_range(3, 0));
      issue(int'($urandom_range(24, 1)), sw, 3'($urandom_range(7, 0)),
            1'($urandom_range(1, 0)), $urandom, {$urandom, $urandom},
            $urandom, t);
      finish_req(t, int'(req_vl), sw, 0);
    end

    issue(32, 0, 3'b000, 1'b0, 32'h80, 64'h55, 32'hD80, t);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_flags",
      {rd_en, red_valid, red_start, red_end, red_lop_sum, done, busy,
       req_ready}, 8'b0000_0001);
    check("mid_rst_addr", {rd_addr, red_addr}, 64'd0);
    check("mid_rst_vec", red_vec0 | red_vec1, 64'd0);
    check("mid_rst_op_sew", {red_opSel, red_sew}, 5'd0);
    rq.delete();
    bq.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tb_rov = 1'b1;
    @(negedge clk);
    tb_rov = 1'b0;
    seen = 0;
    repeat (4) begin
      if (done) seen++;
      @(negedge clk);
    end
    check("late_rov_no_done", seen, 0);

    repeat (3) @(negedge clk);
    check("rq_empty", rq.size(), 0);
    check("bq_empty", bq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
